// File: rtl/uart_tx_8n1_if.sv
// Send-port bundle between the debug unit (master) and the UART transmitter (slave).
// Signal names are given from the transmitter's point of view.
interface uart_tx_8n1_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_tx_start;
   logic [DATA_BITS-1:0] i_tx_data;
   logic                 o_tx_done;
   logic                 o_tx_done_tick;

   modport master (
      output i_tx_start,
      output i_tx_data,
      input  o_tx_done,
      input  o_tx_done_tick
   );

   modport slave (
      input  i_tx_start,
      input  i_tx_data,
      output o_tx_done,
      output o_tx_done_tick
   );
endinterface

// File: rtl/uart_tx_8n1.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop of SB_TICK oversample ticks.
// Generates its own 16x oversample tick from clk; the divider restarts on every accepted byte.
module uart_tx_8n1 #(
   parameter int DATA_BITS = 8,
   parameter int SB_TICK   = 16,
   parameter int BAUD_DIV  = 163
) (
   input  logic         clk,
   input  logic         reset,
   uart_tx_8n1_if.slave s_if,
   output logic         o_tx
);

   localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int TICK_W = 5;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(15);
   localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [BAUD_W-1:0]     r_baud_cnt;
   logic [BAUD_W-1:0]     w_baud_next;
   logic [TICK_W-1:0]     r_tick_cnt;
   logic [TICK_W-1:0]     w_tick_next;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [BIT_W-1:0]      w_bit_next;
   logic [DATA_BITS-1:0]  r_shreg;
   logic [DATA_BITS-1:0]  w_shreg_next;
   logic [DATA_BITS-1:0]  w_shreg_shifted;
   logic                  r_tx;
   logic                  w_tx_next;
   logic                  r_tx_done;
   logic                  w_tx_done_next;
   logic                  w_baud_tick;
   logic                  w_done_tick;

   // Right shift with zero fill; bit 0 is always the bit currently on the line.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
         if (gi == DATA_BITS - 1) begin : g_msb
            assign w_shreg_shifted[gi] = 1'b0;
         end else begin : g_mid
            assign w_shreg_shifted[gi] = r_shreg[gi+1];
         end
      end
   endgenerate

   // Divider is held at zero in IDLE, so the first tick of a frame lands BAUD_DIV cycles after acceptance.
   assign w_baud_tick = (r_state != S_IDLE) && (r_baud_cnt == BAUD_LAST);

   always_comb begin
      w_baud_next = r_baud_cnt;
      if (r_state == S_IDLE || w_baud_tick) begin
         w_baud_next = '0;
      end else begin
         w_baud_next = r_baud_cnt + BAUD_W'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_tick_next  = r_tick_cnt;
      w_bit_next   = r_bit_cnt;
      w_shreg_next = r_shreg;
      w_tx_next    = r_tx;
      w_done_tick  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx_next = 1'b1;
            if (s_if.i_tx_start) begin
               w_shreg_next = s_if.i_tx_data;
               w_tick_next  = '0;
               w_bit_next   = '0;
               w_state_next = S_START;
               w_tx_next    = 1'b0;
            end
         end

         S_START: begin
            if (w_baud_tick) begin
               if (r_tick_cnt == OS_LAST) begin
                  w_tick_next  = '0;
                  w_state_next = S_DATA;
                  w_tx_next    = r_shreg[0];
               end else begin
                  w_tick_next = r_tick_cnt + TICK_W'(1);
               end
            end
         end

         S_DATA: begin
            if (w_baud_tick) begin
               if (r_tick_cnt == OS_LAST) begin
                  w_tick_next  = '0;
                  w_shreg_next = w_shreg_shifted;
                  if (r_bit_cnt == BIT_LAST) begin
                     w_state_next = S_STOP;
                     w_tx_next    = 1'b1;
                  end else begin
                     w_bit_next = r_bit_cnt + BIT_W'(1);
                     w_tx_next  = w_shreg_shifted[0];
                  end
               end else begin
                  w_tick_next = r_tick_cnt + TICK_W'(1);
               end
            end
         end

         S_STOP: begin
            w_tx_next = 1'b1;
            if (w_baud_tick) begin
               if (r_tick_cnt == STOP_LAST) begin
                  w_tick_next  = '0;
                  w_done_tick  = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_tick_next = r_tick_cnt + TICK_W'(1);
               end
            end
         end

         default: begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
         end
      endcase
   end

   // Both line outputs are registered from the next state so the pin never sees decode glitches.
   assign w_tx_done_next = (w_state_next == S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shreg    <= '0;
         r_tx       <= 1'b1;
         r_tx_done  <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_baud_cnt <= w_baud_next;
         r_tick_cnt <= w_tick_next;
         r_bit_cnt  <= w_bit_next;
         r_shreg    <= w_shreg_next;
         r_tx       <= w_tx_next;
         r_tx_done  <= w_tx_done_next;
      end
   end

   assign o_tx                = r_tx;
   assign s_if.o_tx_done      = r_tx_done;
   assign s_if.o_tx_done_tick = w_done_tick;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1 at BAUD_DIV=4 (64 clk per bit, 640-cycle frame).
// A free-running line receiver and done/tick monitor feed queues that the tests inspect.
module tb_uart_tx_8n1;

   localparam int BIT_CYC   = 64;
   localparam int FRAME_CYC = 640;

   logic clk = 1'b0;
   logic reset;
   logic o_tx;

   uart_tx_8n1_if #(.DATA_BITS(8)) u_if ();

   uart_tx_8n1 #(
      .DATA_BITS(8),
      .SB_TICK  (16),
      .BAUD_DIV (4)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .s_if (u_if),
      .o_tx (o_tx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Monitor state: frames decoded from the line, done-low run lengths, tick positions, idle gaps.
   logic [9:0] frm_q[$];
   int         low_q[$];
   int         tickpos_q[$];
   int         gap_q[$];
   int         tick_total = 0;
   int         mon_idx    = 0;
   bit         mon_busy   = 1'b0;
   logic [9:0] mon_bits   = '0;
   logic       mon_prev   = 1'b1;
   int         mon_low    = 0;
   int         mon_high   = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            mon_busy = 1'b0;
            mon_prev = 1'b1;
            mon_low  = 0;
            mon_high = 0;
         end else begin
            if (!mon_busy && mon_prev && (o_tx === 1'b0)) begin
               mon_busy = 1'b1;
               mon_idx  = 0;
            end
            if (mon_busy) begin
               if (mon_idx % BIT_CYC == BIT_CYC / 2)
                  mon_bits[mon_idx / BIT_CYC] = o_tx;
               if (mon_idx == 9 * BIT_CYC + BIT_CYC / 2) begin
                  mon_busy = 1'b0;
                  frm_q.push_back(mon_bits);
                  $display("rx frame: bits=%b byte=%02h", mon_bits, mon_bits[8:1]);
               end
               mon_idx++;
            end
            mon_prev = o_tx;
            if (u_if.o_tx_done === 1'b0) begin
               if (mon_low == 0) gap_q.push_back(mon_high);
               mon_low++;
               mon_high = 0;
            end else begin
               if (mon_low != 0) low_q.push_back(mon_low);
               mon_low = 0;
               mon_high++;
            end
            if (u_if.o_tx_done_tick === 1'b1) begin
               tick_total++;
               tickpos_q.push_back(mon_low);
            end
         end
      end
   end

   task automatic clear_mon();
      frm_q.delete();
      low_q.delete();
      tickpos_q.delete();
      gap_q.delete();
   endtask

   task automatic wait_rx(input string tag, input int n, input int budget);
      int k = 0;
      while (frm_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (40) @(negedge clk);
      check(tag, frm_q.size(), n);
   endtask

   task automatic send_pulse(input logic [7:0] data);
      @(negedge clk);
      u_if.i_tx_data  = data;
      u_if.i_tx_start = 1'b1;
      @(negedge clk);
      u_if.i_tx_start = 1'b0;
   endtask

   task automatic check_timing(input string tag, input int idx);
      if (low_q.size() > idx)     check({tag, "_done_low"}, low_q[idx], FRAME_CYC);
      else                        check({tag, "_done_low_seen"}, low_q.size(), idx + 1);
      if (tickpos_q.size() > idx) check({tag, "_tick_pos"}, tickpos_q[idx], FRAME_CYC);
      else                        check({tag, "_tick_seen"}, tickpos_q.size(), idx + 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base;
      int          k;
      logic [31:0] word;
      logic [7:0]  b;

      reset           = 1'b1;
      u_if.i_tx_start = 1'b0;
      u_if.i_tx_data  = 8'h00;

      // 1: reset values held during and after reset
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_tx_rst", o_tx, 1);
         check("t1_done_rst", u_if.o_tx_done, 1);
         check("t1_tick_rst", u_if.o_tx_done_tick, 0);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("t1_tx_after", o_tx, 1);
      check("t1_done_after", u_if.o_tx_done, 1);
      check("t1_tick_after", u_if.o_tx_done_tick, 0);

      // 2: single 0xA5 frame, line 0,1,0,1,0,0,1,0,1,1 mid-bit
      clear_mon();
      base = tick_total;
      send_pulse(8'hA5);
      check("t2_done_fall", u_if.o_tx_done, 0);
      check("t2_tx_start", o_tx, 0);
      wait_rx("t2_rx_count", 1, 800);
      if (frm_q.size() > 0) check("t2_frame", frm_q[0], 10'b1_1010_0101_0);
      check_timing("t2", 0);
      check("t2_tick_count", tick_total - base, 1);

      // 3: data change and start pulse mid-frame are ignored
      clear_mon();
      base = tick_total;
      send_pulse(8'hA5);
      repeat (290) @(negedge clk);
      u_if.i_tx_data  = 8'h3C;
      u_if.i_tx_start = 1'b1;
      @(negedge clk);
      u_if.i_tx_start = 1'b0;
      wait_rx("t3_rx_count", 1, 800);
      if (frm_q.size() > 0) check("t3_frame", frm_q[0], 10'b1_1010_0101_0);
      repeat (700) @(negedge clk);
      check("t3_no_second", frm_q.size(), 1);
      check("t3_tick_count", tick_total - base, 1);
      check("t3_idle_done", u_if.o_tx_done, 1);

      // 4: start held high, 0x00 then 0xFF back-to-back with one idle cycle
      clear_mon();
      base = tick_total;
      @(negedge clk);
      u_if.i_tx_data  = 8'h00;
      u_if.i_tx_start = 1'b1;
      k = 0;
      while (u_if.o_tx_done_tick !== 1'b1 && k < 800) begin
         @(negedge clk);
         k++;
      end
      check("t4_first_tick", u_if.o_tx_done_tick, 1);
      u_if.i_tx_data = 8'hFF;
      @(negedge clk);
      check("t4_idle_tx", o_tx, 1);
      check("t4_idle_done", u_if.o_tx_done, 1);
      @(negedge clk);
      u_if.i_tx_start = 1'b0;
      check("t4_second_busy", u_if.o_tx_done, 0);
      wait_rx("t4_rx_count", 2, 800);
      if (frm_q.size() > 1) begin
         check("t4_frame0", frm_q[0], 10'b1_0000_0000_0);
         check("t4_frame1", frm_q[1], 10'b1_1111_1111_0);
      end
      check("t4_gap_count", gap_q.size(), 2);
      if (gap_q.size() > 1) check("t4_gap", gap_q[1], 1);
      check_timing("t4a", 0);
      check_timing("t4b", 1);
      check("t4_tick_count", tick_total - base, 2);

      // 5: reset during data bit 3 of 0xA5, then a clean 0x55 frame
      clear_mon();
      send_pulse(8'hA5);
      repeat (280) @(negedge clk);
      check("t5_bit3", o_tx, 0);
      check("t5_busy", u_if.o_tx_done, 0);
      reset = 1'b1;
      @(negedge clk);
      check("t5_tx_rst", o_tx, 1);
      check("t5_done_rst", u_if.o_tx_done, 1);
      @(negedge clk);
      reset = 1'b0;
      clear_mon();
      base = tick_total;
      send_pulse(8'h55);
      wait_rx("t5_rx_count", 1, 800);
      if (frm_q.size() > 0) check("t5_frame", frm_q[0], 10'b1_0101_0101_0);
      check_timing("t5", 0);
      check("t5_tick_count", tick_total - base, 1);

      // 6: debug-unit handshake sends a 32-bit word MSB byte first
      clear_mon();
      base = tick_total;
      word = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
         b = word[31-8*i -: 8];
         k = 0;
         while (u_if.o_tx_done !== 1'b1 && k < 800) begin
            @(negedge clk);
            k++;
         end
         check("t6_ready", u_if.o_tx_done, 1);
         u_if.i_tx_data  = b;
         u_if.i_tx_start = 1'b1;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (u_if.o_tx_done === 1'b1 && k < 5);
         check("t6_accepted", u_if.o_tx_done, 0);
         u_if.i_tx_start = 1'b0;
      end
      wait_rx("t6_rx_count", 4, 800);
      for (int i = 0; i < 4; i++) begin
         b = word[31-8*i -: 8];
         if (frm_q.size() > i) check("t6_byte", frm_q[i], {1'b1, b, 1'b0});
      end
      check("t6_tick_count", tick_total - base, 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
